// File: rtl/red_pitaya_na_sweep_ctrl.sv
// red_pitaya_na_sweep_ctrl: network-analyzer sweep sequencer for one IQ channel.
// Ports: clk_i/rstn_i clock and async active-low reset; start_i/abort_i sweep control;
//   f_start_i/f_step_i/n_points_i/timeout_i sweep setup, sampled at start;
//   iq_addr_o/iq_wen_o/iq_ren_o/iq_wdata_o/iq_rdata_i/iq_ack_i IQ block register bus;
//   res_valid_o/res_ready_i/res_index_o/res_i_o/res_q_o per-point result stream;
//   busy_o/done_o/timeout_o sweep status.
module red_pitaya_na_sweep_ctrl #(
  parameter int NPTBITS = 16,
  parameter int TOBITS  = 32,
  parameter int SUMBITS = 62
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [31:0]        f_start_i,
  input  logic [31:0]        f_step_i,
  input  logic [NPTBITS-1:0] n_points_i,
  input  logic [TOBITS-1:0]  timeout_i,
  output logic [15:0]        iq_addr_o,
  output logic               iq_wen_o,
  output logic               iq_ren_o,
  output logic [31:0]        iq_wdata_o,
  input  logic [31:0]        iq_rdata_i,
  input  logic               iq_ack_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [NPTBITS-1:0] res_index_o,
  output logic [SUMBITS-1:0] res_i_o,
  output logic [SUMBITS-1:0] res_q_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_o
);
  // Bus states are ordered so that a normal advance is state + 1.
  typedef enum logic [2:0] {IDLE, WRF, POLL, RIH, RQL, RQH, OUT} state_t;
  state_t state, state_nxt;
  logic pend;
  logic [31:0] freq, step;
  logic [NPTBITS-1:0] idx, npts;
  logic [TOBITS-1:0] tcnt, tlim;
  logic [30:0] i_lo, i_hi, q_lo, q_hi;
  logic bus_st, acked, to_hit, adv, last, accept;
  always_comb begin
    bus_st = state inside {WRF, POLL, RIH, RQL, RQH};
    acked  = pend && iq_ack_i;
    to_hit = bus_st && tlim != '0 && tcnt + TOBITS'(1) == tlim;
    // A busy poll response re-arms the strobe instead of advancing.
    adv    = acked && !abort_i && !to_hit && !(state == POLL && iq_rdata_i[31]);
    last   = idx == npts - NPTBITS'(1);
    accept = state == OUT && res_ready_i && !abort_i;
    state_nxt = state;
    if (state != IDLE && abort_i) state_nxt = IDLE;
    else if (to_hit) state_nxt = OUT;
    else if (state == IDLE) state_nxt = start_i && n_points_i != '0 ? WRF : IDLE;
    else if (state == OUT) state_nxt = !res_ready_i ? OUT : last ? IDLE : WRF;
    else if (adv) state_nxt = state_t'(state + 3'd1);
    iq_wen_o    = state == WRF && !pend;
    iq_ren_o    = state inside {POLL, RIH, RQL, RQH} && !pend;
    iq_addr_o   = state == WRF  ? 16'h108 :
                  state == POLL ? 16'h140 :
                  state == RIH  ? 16'h144 :
                  state == RQL  ? 16'h148 :
                  state == RQH  ? 16'h14C : 16'h0;
    iq_wdata_o  = state == WRF ? freq : 32'h0;
    res_valid_o = state == OUT;
    res_index_o = state == OUT ? idx : '0;
    res_i_o     = state == OUT ? SUMBITS'({i_hi, i_lo}) : '0;
    res_q_o     = state == OUT ? SUMBITS'({q_hi, q_lo}) : '0;
    busy_o      = state != IDLE;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      pend      <= 1'b0;
      freq      <= '0;
      step      <= '0;
      idx       <= '0;
      npts      <= '0;
      tcnt      <= '0;
      tlim      <= '0;
      i_lo      <= '0;
      i_hi      <= '0;
      q_lo      <= '0;
      q_hi      <= '0;
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      // Leaving a state (advance, abort, timeout) drops any outstanding transaction.
      pend   <= bus_st && state_nxt == state && !acked;
      done_o <= (state == IDLE && start_i && n_points_i == '0) || (accept && last);
      tcnt   <= state_nxt == WRF && state != WRF ? '0 : bus_st ? tcnt + TOBITS'(1) : tcnt;
      if (state == IDLE && start_i) begin
        freq      <= f_start_i;
        step      <= f_step_i;
        npts      <= n_points_i;
        tlim      <= timeout_i;
        idx       <= '0;
        timeout_o <= 1'b0;
      end
      if (accept && !last) begin
        idx  <= idx + NPTBITS'(1);
        freq <= freq + step;
      end
      if (to_hit && !abort_i) begin
        timeout_o <= 1'b1;
        i_lo      <= '0;
        i_hi      <= '0;
        q_lo      <= '0;
        q_hi      <= '0;
      end
      if (adv && state == POLL) i_lo <= iq_rdata_i[30:0];
      if (adv && state == RIH) i_hi <= iq_rdata_i[30:0];
      if (adv && state == RQL) q_lo <= iq_rdata_i[30:0];
      if (adv && state == RQH) q_hi <= iq_rdata_i[30:0];
    end
  end
endmodule
